spi_slave_cfg: RTL and testbench
================================

# spi_slave_cfg

Parametrised SPI slave: the successor to the fixed-mode 32-bit slave. It runs in the system clock domain and oversamples `s_clk`, `ss_n` and `mosi`. All four SPI modes are supported, selected at runtime, and bit order and word width are set by parameters. It streams back-to-back words within one `ss_n` frame, with a buffered valid/ready TX side and a pulsed RX side. It sits between the SPI pads and the register/DMA fabric.

## Interface
- `DATA_WIDTH`, 32: bits per word; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 shifts MSB first, 0 shifts LSB first, on both MOSI and MISO.
- `clk` in 1: system clock; every register uses it.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_mode` in 2: {CPOL, CPHA}; latched when `ss_n` falls.
- `s_clk` in 1: SPI clock from the master.
- `ss_n` in 1: slave select, active low.
- `mosi` in 1: master-out serial data.
- `miso` out 1: slave-out serial data.
- `miso_oe` out 1: pad output enable; equals the synchronised `ss_n` low.
- `tx_data` in DATA_WIDTH: next word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: TX holding register is empty.
- `rx_data` out DATA_WIDTH: last complete received word.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: a frame is active.
- `underrun` out 1: one-cycle pulse when a word is loaded with the holding register empty.
- `frame_err` out 1: one-cycle pulse when `ss_n` deasserts mid-word.

## Operation
- Reset values: `miso`, `miso_oe`, `rx_data`, `rx_valid`, `busy`, `underrun`, `frame_err` are all 0; `tx_ready` is 1. Holding register, shift registers and bit counter are cleared. FSM is in IDLE.
- Edge names:
  - Leading edge is the `s_clk` transition away from CPOL; trailing edge is the return to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Drive edge = the other one.
- TX holding register:
  - Loads `tx_data` when `tx_valid && tx_ready`; `tx_ready` then drops next cycle.
  - Empties when a word is loaded into the TX shifter.
- Word load:
  - Copies the holding register into the TX shifter and puts the first bit on `miso`.
  - If the holding register is empty, loads 0 and pulses `underrun`.
- FSM states:
  - IDLE: `busy`=0 and `miso`=0. On synchronised `ss_n` fall: latch `spi_mode`, clear bit counter, go to ACTIVE. If CPHA=0, word load happens in the same cycle.
  - ACTIVE, on each sample edge:
    - Shift `mosi` into the RX shifter (at LSB if MSB_FIRST, else at MSB) and increment the bit counter.
    - When the counter reaches DATA_WIDTH: `rx_data` ← completed word; pulse `rx_valid` the next cycle; counter wraps to 0.
  - ACTIVE, on each drive edge:
    - If the counter is 0 and at least one sample has occurred in the frame (CPHA=0), or the counter is 0 (CPHA=1): word load.
    - Otherwise: shift out the next bit.
  - ACTIVE, on `ss_n` rise:
    - Counter ≠ 0: pulse `frame_err`, discard the partial word; `rx_data` is unchanged.
    - In all cases return to IDLE and clear the counter.
- `busy` = (state == ACTIVE).
- Simultaneous events:
  - Holding-register load and word load in the same cycle: the word load takes the old content, the new `tx_data` is stored, and `tx_ready` stays 0.
  - `ss_n` rise together with an `s_clk` edge: `ss_n` wins and the edge is ignored.
- `spi_mode` changes during a frame are ignored.
- Bit counter width is `$clog2(DATA_WIDTH)+1`.

## Timing
- Synchronised input = pad after the input stage. The edge detector registers the synchronised `s_clk` once and compares.
- With the synchroniser (see Configuration): an edge is acted on 3 `clk` cycles after the pad edge. Without it: 1 cycle.
- `miso` updates 1 cycle after the edge is detected.
- `rx_valid` rises 1 cycle after the final sample edge is detected.
- `clk` must be ≥ 8× `s_clk`. Each `s_clk` phase must be ≥ 4 `clk` cycles.
- Back-to-back words have no gap; `tx_data` must be presented before the drive edge that loads it.

## Configuration
- `SPI_SLAVE_CFG_SYNC_EN`:
  - Defined: two-flop synchronisers on `s_clk`, `ss_n` and `mosi`; latency as in Timing.
  - Undefined: pad inputs feed the edge detector and logic directly, for source-synchronous or already-synchronised use; latency reduces by 2 cycles.

## Test plan
- Mode 0, DATA_WIDTH=32, MSB first: master sends 0xA5A50F0F while `tx_data`=0x12345678 was preloaded → `rx_data`=0xA5A50F0F with one `rx_valid` pulse; master receives 0x12345678.
- Mode 3, two back-to-back words in one frame with TX 0xDEADBEEF then 0xCAFEF00D → master receives both in order; two `rx_valid` pulses; `tx_ready` rises after each load.
- MSB_FIRST=0, DATA_WIDTH=8, mode 1: master sends 0x01 LSB-first → `rx_data`=0x01; slave TX 0x80 appears on the last bit.
- No `tx_valid` before frame start, mode 2 → `underrun` pulses once; `miso` is 0 for all 32 bits; RX still completes.
- `ss_n` rises after 13 bits → `frame_err` pulse, no `rx_valid`, `rx_data` unchanged. A following full frame works normally.
- `rst_n` asserted mid-frame → all outputs take reset values immediately. After release with `ss_n` high, the next frame starts cleanly from bit 0.

Source files
------------

// File: rtl/spi_slave_cfg.sv
// SPI slave with runtime-selected mode, parametric word width and bit order,
// oversampled in the clk domain. Define SPI_SLAVE_CFG_SYNC_EN to add input synchronisers.
module spi_slave_cfg #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            spi_mode,
  input  logic                  s_clk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic                  sclk_s, ss_s, mosi_s;
  logic                  sclk_q, ss_q;
  logic                  cpol_q, cpha_q;
  logic                  sampled;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next;
  logic [DATA_WIDTH-1:0] hold_reg, load_word;
  logic                  hold_full, hold_load, word_load;
  logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                  sample_edge, drive_edge, ss_fall;

`ifdef SPI_SLAVE_CFG_SYNC_EN
  logic [1:0] sclk_ff, ss_ff, mosi_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff <= '0;
      ss_ff   <= '1;
      mosi_ff <= '0;
    end else begin
      sclk_ff <= {sclk_ff[0], s_clk};
      ss_ff   <= {ss_ff[0], ss_n};
      mosi_ff <= {mosi_ff[0], mosi};
    end
  end

  assign sclk_s = sclk_ff[1];
  assign ss_s   = ss_ff[1];
  assign mosi_s = mosi_ff[1];
`else
  assign sclk_s = s_clk;
  assign ss_s   = ss_n;
  assign mosi_s = mosi;
`endif

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      ss_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      ss_q   <= ss_s;
    end
  end

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;
  assign ss_fall     = ss_q & ~ss_s;

  assign tx_ready  = ~hold_full;
  assign hold_load = tx_valid & ~hold_full;
  assign load_word = hold_full ? hold_reg : '0;
  assign busy      = (state == ACTIVE);

  always_comb begin
    if (MSB_FIRST) rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    else           rx_next = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
  end

  // A word load at frame start (CPHA=0) or at a drive edge on a word boundary;
  // with CPHA=0 the boundary only counts once something has been sampled.
  always_comb begin
    word_load = 1'b0;
    if (state == IDLE)
      word_load = ss_fall & ~spi_mode[0];
    else if (!ss_s && drive_edge && bit_cnt == '0)
      word_load = cpha_q | sampled;
  end

  // Holding register: a same-cycle fill and drain leaves it full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (hold_load) hold_reg <= tx_data;
      hold_full <= hold_load | (hold_full & ~word_load);
      underrun  <= word_load & ~hold_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sampled   <= 1'b0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= ~ss_s;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (ss_fall) begin
            state   <= ACTIVE;
            cpol_q  <= spi_mode[1];
            cpha_q  <= spi_mode[0];
            bit_cnt <= '0;
            sampled <= 1'b0;
            if (word_load) begin
              miso     <= first_bit(load_word);
              tx_shift <= shift_out(load_word);
            end
          end
        end
        ACTIVE: begin
          // Deselect takes priority over any s_clk edge seen in the same cycle.
          if (ss_s) begin
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
            sampled   <= 1'b0;
            rx_shift  <= '0;
            miso      <= 1'b0;
          end else begin
            if (sample_edge) begin
              sampled  <= 1'b1;
              rx_shift <= rx_next;
              if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
            if (drive_edge) begin
              if (word_load) begin
                miso     <= first_bit(load_word);
                tx_shift <= shift_out(load_word);
              end else begin
                miso     <= first_bit(tx_shift);
                tx_shift <= shift_out(tx_shift);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: a 32-bit MSB-first and an 8-bit LSB-first slave share
// s_clk/mosi; a bit-level master and a holding-queue model supply expected values.
module tb_spi_slave_cfg;

  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, s_clk, mosi, ss_n_a, ss_n_b;
  logic [1:0]  spi_mode;
  logic        miso_a, miso_oe_a, tx_valid_a, tx_ready_a, rx_valid_a, busy_a, underrun_a, frame_err_a;
  logic [31:0] tx_data_a, rx_data_a;
  logic        miso_b, miso_oe_b, tx_valid_b, tx_ready_b, rx_valid_b, busy_b, underrun_b, frame_err_b;
  logic [7:0]  tx_data_b, rx_data_b;

  int checks = 0;
  int errors = 0;
  int rxv_cnt[2]  = '{0, 0};
  int und_cnt[2]  = '{0, 0};
  int ferr_cnt[2] = '{0, 0};
  int exp_und[2]  = '{0, 0};
  logic [31:0] rxq0[$];
  logic [31:0] hold_q0[$];
  logic [31:0] hold_q1[$];
  logic [31:0] exp_rx_a;

  spi_slave_cfg #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_mode(spi_mode), .s_clk(s_clk), .ss_n(ss_n_a),
    .mosi(mosi), .miso(miso_a), .miso_oe(miso_oe_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .busy(busy_a), .underrun(underrun_a), .frame_err(frame_err_a)
  );

  spi_slave_cfg #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_mode(spi_mode), .s_clk(s_clk), .ss_n(ss_n_b),
    .mosi(mosi), .miso(miso_b), .miso_oe(miso_oe_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .busy(busy_b), .underrun(underrun_b), .frame_err(frame_err_b)
  );

  always @(negedge clk) begin
    if (rx_valid_a) begin
      rxv_cnt[0]++;
      rxq0.push_back(rx_data_a);
    end
    if (rx_valid_b)  rxv_cnt[1]++;
    if (underrun_a)  und_cnt[0]++;
    if (underrun_b)  und_cnt[1]++;
    if (frame_err_a) ferr_cnt[0]++;
    if (frame_err_b) ferr_cnt[1]++;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: one word per load taken from the pushed sequence, zero when empty.
  task automatic model_push(input int sel, input logic [31:0] w);
    if (sel == 0) hold_q0.push_back(w);
    else          hold_q1.push_back(w & 32'hFF);
  endtask

  task automatic model_load(input int sel, output logic [31:0] w);
    w = '0;
    if (sel == 0) begin
      if (hold_q0.size() > 0) w = hold_q0.pop_front();
      else exp_und[0]++;
    end else begin
      if (hold_q1.size() > 0) w = hold_q1.pop_front();
      else exp_und[1]++;
    end
  endtask

  function automatic int n_loads(input logic cpha, input int nbits, input int dw);
    if (cpha) return (nbits == 0) ? 0 : (nbits - 1) / dw + 1;
    return 1 + nbits / dw;
  endfunction

  task automatic model_frame(input int sel, input logic [1:0] mode, input int nbits,
                             output logic [31:0] e0, output logic [31:0] e1);
    logic [31:0] t;
    int n;
    n = n_loads(mode[0], nbits, (sel == 0) ? 32 : 8);
    e0 = '0;
    e1 = '0;
    for (int i = 0; i < n; i++) begin
      model_load(sel, t);
      if (i == 0) e0 = t;
      else if (i == 1) e1 = t;
    end
  endtask

  task automatic push_tx(input int sel, input logic [31:0] w);
    int t;
    t = 0;
    while (((sel == 0) ? tx_ready_a : tx_ready_b) !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("[TB] FAIL push_tx_timeout got tx_ready=0 want 1");
    end else begin
      if (sel == 0) begin tx_data_a = w;      tx_valid_a = 1'b1; end
      else          begin tx_data_b = w[7:0]; tx_valid_b = 1'b1; end
      @(negedge clk);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
    end
  endtask

  // Bit-level SPI master; word k of the stream comes from w0/w1 and lands in r0/r1.
  task automatic spi_xfer(input int sel, input logic [1:0] mode, input int nbits,
                          input logic [31:0] w0, input logic [31:0] w1,
                          output logic [31:0] r0, output logic [31:0] r1);
    int dw, k, idx;
    logic cpol, cpha, mbit;
    logic [31:0] wsel;
    dw   = (sel == 0) ? 32 : 8;
    cpol = mode[1];
    cpha = mode[0];
    r0 = '0;
    r1 = '0;
    spi_mode = mode;
    s_clk = cpol;
    mosi = 1'b0;
    wait_cyc(HALF);
    if (sel == 0) ss_n_a = 1'b0; else ss_n_b = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      k    = b / dw;
      idx  = (sel == 0) ? (dw - 1 - (b % dw)) : (b % dw);
      wsel = (k == 0) ? w0 : w1;
      if (!cpha) begin
        mosi = wsel[idx];
        wait_cyc(HALF);
        s_clk = ~cpol;
        mbit = (sel == 0) ? miso_a : miso_b;
        wait_cyc(HALF);
        s_clk = cpol;
      end else begin
        wait_cyc(HALF);
        s_clk = ~cpol;
        mosi = wsel[idx];
        wait_cyc(HALF);
        s_clk = cpol;
        mbit = (sel == 0) ? miso_a : miso_b;
      end
      if (k == 0) r0[idx] = mbit; else r1[idx] = mbit;
    end
    wait_cyc(HALF);
    ss_n_a = 1'b1;
    ss_n_b = 1'b1;
    wait_cyc(HALF);
    mosi = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(4);
    checks++;
    if ({miso_a, miso_oe_a, rx_valid_a, busy_a, underrun_a, frame_err_a, tx_ready_a} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset_flags_a got %b want 0000001", {miso_a, miso_oe_a, rx_valid_a, busy_a, underrun_a, frame_err_a, tx_ready_a});
    end
    checks++;
    if (rx_data_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_rx_a got %h want 0", rx_data_a); end
    checks++;
    if ({miso_b, miso_oe_b, rx_valid_b, busy_b, underrun_b, frame_err_b, tx_ready_b} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL reset_flags_b got %b want 0000001", {miso_b, miso_oe_b, rx_valid_b, busy_b, underrun_b, frame_err_b, tx_ready_b});
    end
    checks++;
    if (rx_data_b !== 8'h0) begin errors++; $display("[TB] FAIL reset_rx_b got %h want 0", rx_data_b); end
    rst_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_mode0();
    logic [31:0] r0, r1, e0, e1;
    int rv;
    rv = rxv_cnt[0];
    push_tx(0, 32'h12345678);
    model_push(0, 32'h12345678);
    model_frame(0, 2'b00, 32, e0, e1);
    fork
      spi_xfer(0, 2'b00, 32, 32'hA5A50F0F, 32'h0, r0, r1);
      begin
        wait_cyc(3 * HALF);
        checks++;
        if ({busy_a, miso_oe_a} !== 2'b11) begin
          errors++;
          $display("[TB] FAIL mode0_busy got %b want 11", {busy_a, miso_oe_a});
        end
      end
    join
    exp_rx_a = 32'hA5A50F0F;
    checks++;
    if (r0 !== e0) begin errors++; $display("[TB] FAIL mode0_miso got %h want %h", r0, e0); end
    checks++;
    if (rx_data_a !== exp_rx_a) begin errors++; $display("[TB] FAIL mode0_rx got %h want %h", rx_data_a, exp_rx_a); end
    checks++;
    if (rxv_cnt[0] - rv !== 1) begin errors++; $display("[TB] FAIL mode0_rxv got %0d want 1", rxv_cnt[0] - rv); end
    checks++;
    if (und_cnt[0] !== exp_und[0]) begin errors++; $display("[TB] FAIL mode0_und got %0d want %0d", und_cnt[0], exp_und[0]); end
    checks++;
    if ({busy_a, tx_ready_a} !== 2'b01) begin errors++; $display("[TB] FAIL mode0_idle got %b want 01", {busy_a, tx_ready_a}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r0, r1, e0, e1, w0, w1;
    int rv, qs;
    w0 = $urandom;
    w1 = $urandom;
    rv = rxv_cnt[0];
    qs = rxq0.size();
    push_tx(0, 32'hDEADBEEF);
    model_push(0, 32'hDEADBEEF);
    model_push(0, 32'hCAFEF00D);
    model_frame(0, 2'b11, 64, e0, e1);
    fork
      spi_xfer(0, 2'b11, 64, w0, w1, r0, r1);
      push_tx(0, 32'hCAFEF00D);
    join
    exp_rx_a = w1;
    checks++;
    if ({r0, r1} !== {e0, e1}) begin errors++; $display("[TB] FAIL b2b_miso got %h %h want %h %h", r0, r1, e0, e1); end
    checks++;
    if (rxv_cnt[0] - rv !== 2) begin errors++; $display("[TB] FAIL b2b_rxv got %0d want 2", rxv_cnt[0] - rv); end
    checks++;
    if (rxq0.size() < qs + 2) begin
      errors++;
      $display("[TB] FAIL b2b_rxq got %0d words want 2", rxq0.size() - qs);
    end else if ({rxq0[qs], rxq0[qs+1]} !== {w0, w1}) begin
      errors++;
      $display("[TB] FAIL b2b_rxq got %h %h want %h %h", rxq0[qs], rxq0[qs+1], w0, w1);
    end
    checks++;
    if (und_cnt[0] !== exp_und[0]) begin errors++; $display("[TB] FAIL b2b_und got %0d want %0d", und_cnt[0], exp_und[0]); end
    checks++;
    if (tx_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b want 1", tx_ready_a); end
  endtask

  task automatic test_lsb_first();
    logic [31:0] r0, r1, e0, e1;
    int rv;
    rv = rxv_cnt[1];
    push_tx(1, 32'h80);
    model_push(1, 32'h80);
    model_frame(1, 2'b01, 8, e0, e1);
    spi_xfer(1, 2'b01, 8, 32'h01, 32'h0, r0, r1);
    checks++;
    if (r0[7:0] !== e0[7:0]) begin errors++; $display("[TB] FAIL lsb_miso got %h want %h", r0[7:0], e0[7:0]); end
    checks++;
    if (rx_data_b !== 8'h01) begin errors++; $display("[TB] FAIL lsb_rx got %h want 01", rx_data_b); end
    checks++;
    if (rxv_cnt[1] - rv !== 1) begin errors++; $display("[TB] FAIL lsb_rxv got %0d want 1", rxv_cnt[1] - rv); end
    checks++;
    if (und_cnt[1] !== exp_und[1]) begin errors++; $display("[TB] FAIL lsb_und got %0d want %0d", und_cnt[1], exp_und[1]); end
  endtask

  task automatic test_underrun();
    logic [31:0] r0, r1, e0, tmp, w, late;
    int rv;
    w = $urandom;
    late = $urandom;
    rv = rxv_cnt[0];
    model_load(0, e0);
    model_push(0, late);
    model_load(0, tmp);
    fork
      spi_xfer(0, 2'b10, 32, w, 32'h0, r0, r1);
      begin
        wait_cyc(20 * HALF);
        push_tx(0, late);
      end
    join
    exp_rx_a = w;
    checks++;
    if (r0 !== e0) begin errors++; $display("[TB] FAIL underrun_miso got %h want %h", r0, e0); end
    checks++;
    if (und_cnt[0] !== exp_und[0]) begin errors++; $display("[TB] FAIL underrun_cnt got %0d want %0d", und_cnt[0], exp_und[0]); end
    checks++;
    if (rx_data_a !== w) begin errors++; $display("[TB] FAIL underrun_rx got %h want %h", rx_data_a, w); end
    checks++;
    if (rxv_cnt[0] - rv !== 1) begin errors++; $display("[TB] FAIL underrun_rxv got %0d want 1", rxv_cnt[0] - rv); end
  endtask

  task automatic test_frame_err();
    logic [31:0] r0, r1, e0, e1, p, w;
    int rv, fe;
    p  = $urandom;
    rv = rxv_cnt[0];
    fe = ferr_cnt[0];
    push_tx(0, p);
    model_push(0, p);
    model_frame(0, 2'b00, 13, e0, e1);
    spi_xfer(0, 2'b00, 13, $urandom, 32'h0, r0, r1);
    checks++;
    if (ferr_cnt[0] - fe !== 1) begin errors++; $display("[TB] FAIL ferr_pulse got %0d want 1", ferr_cnt[0] - fe); end
    checks++;
    if (rxv_cnt[0] - rv !== 0) begin errors++; $display("[TB] FAIL ferr_rxv got %0d want 0", rxv_cnt[0] - rv); end
    checks++;
    if (rx_data_a !== exp_rx_a) begin errors++; $display("[TB] FAIL ferr_rx got %h want %h", rx_data_a, exp_rx_a); end
    checks++;
    if ((r0 >> 19) !== (e0 >> 19)) begin errors++; $display("[TB] FAIL ferr_miso got %h want %h", r0 >> 19, e0 >> 19); end
    p = $urandom;
    w = $urandom;
    push_tx(0, p);
    model_push(0, p);
    model_frame(0, 2'b00, 32, e0, e1);
    spi_xfer(0, 2'b00, 32, w, 32'h0, r0, r1);
    exp_rx_a = w;
    checks++;
    if ({r0, rx_data_a} !== {e0, w}) begin errors++; $display("[TB] FAIL ferr_next got %h %h want %h %h", r0, rx_data_a, e0, w); end
    checks++;
    if (ferr_cnt[0] - fe !== 1) begin errors++; $display("[TB] FAIL ferr_next_err got %0d want 1", ferr_cnt[0] - fe); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r0, r1, e0, e1, p, w;
    int rv;
    p = $urandom;
    push_tx(0, p);
    model_push(0, p);
    spi_mode = 2'b00;
    s_clk = 1'b0;
    wait_cyc(HALF);
    ss_n_a = 1'b0;
    model_load(0, e0);
    wait_cyc(HALF);
    for (int i = 0; i < 3; i++) begin
      s_clk = 1'b1; wait_cyc(HALF);
      s_clk = 1'b0; wait_cyc(HALF);
    end
    push_tx(0, $urandom);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({miso_a, miso_oe_a, rx_valid_a, busy_a, underrun_a, frame_err_a, tx_ready_a} !== 7'b0000001) begin
      errors++;
      $display("[TB] FAIL midrst_flags_a got %b want 0000001", {miso_a, miso_oe_a, rx_valid_a, busy_a, underrun_a, frame_err_a, tx_ready_a});
    end
    checks++;
    if ({rx_data_a, rx_data_b} !== 40'h0) begin errors++; $display("[TB] FAIL midrst_rx got %h %h want 0 0", rx_data_a, rx_data_b); end
    hold_q0.delete();
    hold_q1.delete();
    exp_rx_a = '0;
    ss_n_a = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    p  = $urandom;
    w  = $urandom;
    rv = rxv_cnt[0];
    push_tx(0, p);
    model_push(0, p);
    model_frame(0, 2'b00, 32, e0, e1);
    spi_xfer(0, 2'b00, 32, w, 32'h0, r0, r1);
    exp_rx_a = w;
    checks++;
    if ({r0, rx_data_a} !== {e0, w}) begin errors++; $display("[TB] FAIL midrst_next got %h %h want %h %h", r0, rx_data_a, e0, w); end
    checks++;
    if (rxv_cnt[0] - rv !== 1) begin errors++; $display("[TB] FAIL midrst_rxv got %0d want 1", rxv_cnt[0] - rv); end
  endtask

  task automatic test_random();
    logic [31:0] r0, r1, e0, e1, w, t, got;
    logic [1:0] mode;
    int sel, dw, rv;
    for (int it = 0; it < 6; it++) begin
      sel  = $urandom_range(0, 1);
      mode = 2'($urandom_range(0, 3));
      dw   = (sel == 0) ? 32 : 8;
      w    = $urandom;
      t    = $urandom;
      if (sel == 1) begin w &= 32'hFF; t &= 32'hFF; end
      rv = rxv_cnt[sel];
      push_tx(sel, t);
      model_push(sel, t);
      model_frame(sel, mode, dw, e0, e1);
      spi_xfer(sel, mode, dw, w, 32'h0, r0, r1);
      if (sel == 0) exp_rx_a = w;
      got = (sel == 0) ? rx_data_a : {24'h0, rx_data_b};
      checks++;
      if (r0 !== e0) begin errors++; $display("[TB] FAIL rand%0d_miso got %h want %h", it, r0, e0); end
      checks++;
      if (got !== w) begin errors++; $display("[TB] FAIL rand%0d_rx got %h want %h", it, got, w); end
      checks++;
      if (rxv_cnt[sel] - rv !== 1) begin errors++; $display("[TB] FAIL rand%0d_rxv got %0d want 1", it, rxv_cnt[sel] - rv); end
      checks++;
      if (und_cnt[sel] !== exp_und[sel]) begin errors++; $display("[TB] FAIL rand%0d_und got %0d want %0d", it, und_cnt[sel], exp_und[sel]); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    spi_mode   = 2'b00;
    s_clk      = 1'b0;
    mosi       = 1'b0;
    ss_n_a     = 1'b1;
    ss_n_b     = 1'b1;
    tx_data_a  = '0;
    tx_valid_a = 1'b0;
    tx_data_b  = '0;
    tx_valid_b = 1'b0;
    exp_rx_a   = '0;
    test_reset();
    test_mode0();
    test_back_to_back();
    test_lsb_first();
    test_underrun();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
